// File: rtl/move_link_ctrl.sv
// Move-exchange sequencer between the game FSM and the UART tx/rx pair.
// Sends local moves with ACK/retry and acknowledges received moves, dropping duplicates.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | nothing in flight; services rx_pend first, then send_pend
// S_ACK_TX   | ACK frame: trigger one cycle after entry, then the frame time
// S_SEND_TX  | local move frame: trigger on entry, then the frame time
// S_WAIT_ACK | waiting for the peer ACK, retransmits on timeout
// S_ERROR    | retries exhausted; only reset leaves this state
module move_link_ctrl #(
    parameter int          FRAME_CYCLES   = 67_710,
    parameter int          TIMEOUT_CYCLES = 650_000,
    parameter int          MAX_RETRIES    = 3,
    parameter logic [7:0]  ACK_BYTE       = 8'hFF
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       move_send_in,
    input  logic [7:0] move_in,
    input  logic       rx_ready_in,
    input  logic [7:0] rx_data_in,
    output logic       tx_trigger_out,
    output logic [7:0] tx_data_out,
    output logic       move_valid_out,
    output logic [7:0] move_out,
    output logic       send_done_out,
    output logic       link_err_out,
    output logic       busy_out
);

    localparam int RW = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [RW-1:0] MAX_R      = RW'(MAX_RETRIES);
    localparam logic [19:0]   ACK_END    = 20'(FRAME_CYCLES);
    localparam logic [19:0]   SEND_END   = 20'(FRAME_CYCLES - 1);
    localparam logic [19:0]   TIMEOUT_TC = 20'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK_TX,
        S_SEND_TX,
        S_WAIT_ACK,
        S_ERROR
    } state_t;

    state_t         state, state_nxt;
    logic [19:0]    cnt, cnt_nxt;
    logic [RW-1:0]  retry_cnt, retry_nxt;
    logic           send_pend, send_pend_nxt;
    logic [7:0]     send_byte, send_byte_nxt;
    logic           rx_pend, rx_pend_nxt;
    logic [7:0]     rx_byte, rx_byte_nxt;
    logic [7:0]     last_rx, last_rx_nxt;
    logic           last_rx_vld, last_rx_vld_nxt;
    logic           trig_nxt, valid_nxt, done_nxt, err_nxt;
    logic [7:0]     tx_data_nxt, move_nxt;
    logic           rx_move, rx_ack;

    assign rx_move  = rx_ready_in && (rx_data_in != ACK_BYTE);
    assign rx_ack   = rx_ready_in && (rx_data_in == ACK_BYTE);
    assign busy_out = (state != S_IDLE) || send_pend || rx_pend;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= S_IDLE;
            cnt            <= '0;
            retry_cnt      <= '0;
            send_pend      <= 1'b0;
            send_byte      <= '0;
            rx_pend        <= 1'b0;
            rx_byte        <= '0;
            last_rx        <= '0;
            last_rx_vld    <= 1'b0;
            tx_trigger_out <= 1'b0;
            tx_data_out    <= '0;
            move_valid_out <= 1'b0;
            move_out       <= '0;
            send_done_out  <= 1'b0;
            link_err_out   <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            retry_cnt      <= retry_nxt;
            send_pend      <= send_pend_nxt;
            send_byte      <= send_byte_nxt;
            rx_pend        <= rx_pend_nxt;
            rx_byte        <= rx_byte_nxt;
            last_rx        <= last_rx_nxt;
            last_rx_vld    <= last_rx_vld_nxt;
            tx_trigger_out <= trig_nxt;
            tx_data_out    <= tx_data_nxt;
            move_valid_out <= valid_nxt;
            move_out       <= move_nxt;
            send_done_out  <= done_nxt;
            link_err_out   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        retry_nxt       = retry_cnt;
        send_pend_nxt   = send_pend;
        send_byte_nxt   = send_byte;
        rx_pend_nxt     = rx_pend;
        rx_byte_nxt     = rx_byte;
        last_rx_nxt     = last_rx;
        last_rx_vld_nxt = last_rx_vld;
        trig_nxt        = 1'b0;
        valid_nxt       = 1'b0;
        done_nxt        = 1'b0;
        err_nxt         = link_err_out;
        tx_data_nxt     = tx_data_out;
        move_nxt        = move_out;

        // Capture first so IDLE can act on a same-cycle request (one-cycle latency).
        if (state != S_ERROR) begin
            if (rx_move) begin
                rx_pend_nxt = 1'b1;
                rx_byte_nxt = rx_data_in;
            end
            if (move_send_in) begin
                send_pend_nxt = 1'b1;
                send_byte_nxt = move_in;
            end
        end

        case (state)
            S_IDLE: begin
                if (rx_pend_nxt) begin
                    rx_pend_nxt = 1'b0;
                    tx_data_nxt = ACK_BYTE;
                    state_nxt   = S_ACK_TX;
                    if (!last_rx_vld || (rx_byte_nxt != last_rx)) begin
                        valid_nxt       = 1'b1;
                        move_nxt        = rx_byte_nxt;
                        last_rx_nxt     = rx_byte_nxt;
                        last_rx_vld_nxt = 1'b1;
                    end
                end else if (send_pend_nxt) begin
                    send_pend_nxt   = 1'b0;
                    retry_nxt       = '0;
                    last_rx_vld_nxt = 1'b0;
                    trig_nxt        = 1'b1;
                    tx_data_nxt     = send_byte_nxt;
                    state_nxt       = S_SEND_TX;
                end
            end
            S_ACK_TX: begin
                if (cnt == 20'd0) trig_nxt = 1'b1;
                if (cnt == ACK_END) state_nxt = S_IDLE;
            end
            S_SEND_TX: begin
                if (cnt == SEND_END) state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // tx_data_out still holds the in-flight move, so a retry resends it as is.
                if (rx_ack) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == TIMEOUT_TC) begin
                    if (retry_cnt < MAX_R) begin
                        retry_nxt       = retry_cnt + 1'b1;
                        last_rx_vld_nxt = 1'b0;
                        trig_nxt        = 1'b1;
                        state_nxt       = S_SEND_TX;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                err_nxt = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase

        if ((state_nxt != state) || (state == S_IDLE) || (state == S_ERROR))
            cnt_nxt = '0;
        else
            cnt_nxt = cnt + 20'd1;
    end

endmodule

// File: tb/tb_move_link_ctrl.sv
// Scoreboard bench for move_link_ctrl: stimulus queues expected pulses,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_move_link_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       move_send_in = 1'b0;
    logic [7:0] move_in = '0;
    logic       rx_ready_in = 1'b0;
    logic [7:0] rx_data_in = '0;
    logic       tx_trigger_out;
    logic [7:0] tx_data_out;
    logic       move_valid_out;
    logic [7:0] move_out;
    logic       send_done_out;
    logic       link_err_out;
    logic       busy_out;

    move_link_ctrl #(
        .FRAME_CYCLES(20), .TIMEOUT_CYCLES(100), .MAX_RETRIES(2), .ACK_BYTE(8'hFF)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .move_send_in(move_send_in), .move_in(move_in),
        .rx_ready_in(rx_ready_in), .rx_data_in(rx_data_in),
        .tx_trigger_out(tx_trigger_out), .tx_data_out(tx_data_out),
        .move_valid_out(move_valid_out), .move_out(move_out),
        .send_done_out(send_done_out), .link_err_out(link_err_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef enum logic [1:0] {EV_TRIG, EV_VALID, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    logic err_prev = 1'b0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] d, input int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_%s: got data %02h at cycle %0d, required no event",
                     k.name(), d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d || e.cyc != cyc) begin
                mismatched++;
                $display("FAIL event_%s: got %s data %02h cycle %0d, required %s data %02h cycle %0d",
                         e.kind.name(), k.name(), d, cyc, e.kind.name(), e.data, e.cyc);
            end
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    always @(negedge clk_in) begin
        if (move_valid_out) check_ev(EV_VALID, move_out);
        if (send_done_out) check_ev(EV_DONE, 8'h00);
        if (tx_trigger_out) check_ev(EV_TRIG, tx_data_out);
        if (link_err_out && !err_prev) check_ev(EV_ERR, 8'h00);
        err_prev <= link_err_out;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_send(input logic [7:0] b);
        move_send_in = 1'b1;
        move_in      = b;
        tick();
        move_send_in = 1'b0;
    endtask

    task automatic pulse_rx(input logic [7:0] b);
        rx_ready_in = 1'b1;
        rx_data_in  = b;
        tick();
        rx_ready_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_trig"},  {7'd0, tx_trigger_out}, 8'h00);
        check_val({tag, "_txd"},   tx_data_out, 8'h00);
        check_val({tag, "_valid"}, {7'd0, move_valid_out}, 8'h00);
        check_val({tag, "_move"},  move_out, 8'h00);
        check_val({tag, "_done"},  {7'd0, send_done_out}, 8'h00);
        check_val({tag, "_err"},   {7'd0, link_err_out}, 8'h00);
        check_val({tag, "_busy"},  {7'd0, busy_out}, 8'h00);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        tick(); tick(); tick();
        check_all_zero("reset");
        rst_in = 1'b1;
        tick(); tick();

        // Send and ACK
        t = cyc;
        expect_ev(EV_TRIG, 8'h34, t + 1);
        expect_ev(EV_DONE, 8'h00, t + 51);
        pulse_send(8'h34);
        wait_until(t + 50);
        pulse_rx(8'hFF);
        wait_until(t + 55);
        check_val("send_ack_err",  {7'd0, link_err_out}, 8'h00);
        check_val("send_ack_busy", {7'd0, busy_out}, 8'h00);

        // Collision: rx serviced first, then the buffered send
        t = cyc;
        expect_ev(EV_VALID, 8'h52, t + 1);
        expect_ev(EV_TRIG,  8'hFF, t + 2);
        expect_ev(EV_TRIG,  8'h11, t + 23);
        expect_ev(EV_DONE,  8'h00, t + 61);
        move_send_in = 1'b1; move_in = 8'h11;
        rx_ready_in  = 1'b1; rx_data_in = 8'h52;
        tick();
        move_send_in = 1'b0; rx_ready_in = 1'b0;
        wait_until(t + 60);
        pulse_rx(8'hFF);
        wait_until(t + 65);

        // Receive and ACK
        t = cyc;
        expect_ev(EV_VALID, 8'h52, t + 1);
        expect_ev(EV_TRIG,  8'hFF, t + 2);
        pulse_rx(8'h52);
        wait_until(t + 25);
        check_val("rx_move_held", move_out, 8'h52);

        // Duplicate: re-ACK only
        t = cyc;
        expect_ev(EV_TRIG, 8'hFF, t + 2);
        pulse_rx(8'h52);
        wait_until(t + 25);

        // Local send clears duplicate history
        t = cyc;
        expect_ev(EV_TRIG, 8'h77, t + 1);
        expect_ev(EV_DONE, 8'h00, t + 31);
        pulse_send(8'h77);
        wait_until(t + 30);
        pulse_rx(8'hFF);
        wait_until(t + 35);
        t = cyc;
        expect_ev(EV_VALID, 8'h52, t + 1);
        expect_ev(EV_TRIG,  8'hFF, t + 2);
        pulse_rx(8'h52);
        wait_until(t + 25);

        // Reset during WAIT_ACK; a late ACK must be ignored
        t = cyc;
        expect_ev(EV_TRIG, 8'h5A, t + 1);
        pulse_send(8'h5A);
        wait_until(t + 40);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        check_all_zero("midreset");
        wait_until(t + 45);
        pulse_rx(8'hFF);
        wait_until(t + 60);
        check_val("midreset_idle_busy", {7'd0, busy_out}, 8'h00);

        // Retry exhaustion
        t = cyc;
        expect_ev(EV_TRIG, 8'h34, t + 1);
        expect_ev(EV_TRIG, 8'h34, t + 122);
        expect_ev(EV_TRIG, 8'h34, t + 243);
        expect_ev(EV_ERR,  8'h00, t + 364);
        pulse_send(8'h34);
        wait_until(t + 380);
        pulse_send(8'h21);
        wait_until(t + 500);
        check_val("err_sticky", {7'd0, link_err_out}, 8'h01);

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            compared++;
            mismatched++;
            $display("FAIL missing_%s: got nothing, required data %02h at cycle %0d",
                     e.kind.name(), e.data, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
